// File: rtl/fifo_pkg.sv
// Shared helpers for the block-RAM FIFO family.
package fifo_pkg;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int fifo_count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Small register FIFO that lands words returning from the block-RAM read port.
// Pointers wrap explicitly so DEPTH may be any value.
module fifo_stream_reader_buf
  import fifo_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CW    = fifo_count_width(DEPTH),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             clear,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign rd_en = rd & (count != '0);
  assign wr_en = wr & ((count != FULL) | rd_en);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= ptr_inc(tail);
      if (rd_en) head <= ptr_inc(head);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) mem[tail] <= wdata;
  end

  // Storage is not reset, so an empty buffer presents zero instead of stale words.
  assign rdata = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read stage for the block-RAM FIFO: converts empty/read/latency-delayed data into
// a first-word-fall-through valid/ready stream with credit-based read issue.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter  int WIDTH        = 8,
  parameter  int READ_LATENCY = 1,
  localparam int BUF          = READ_LATENCY + 2,
  localparam int CW           = fifo_count_width(BUF)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_fifo_empty,
  output logic             o_fifo_read,
  input  logic [WIDTH-1:0] i_fifo_rdata,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW:0] BUF_LIMIT = (CW + 1)'(BUF);

  logic [READ_LATENCY-1:0] tag_sr;
  logic [READ_LATENCY-1:0] tag_shift;
  logic [CW-1:0]           occ;
  logic [CW-1:0]           inflight;
  logic [CW:0]             credit;
  logic                    capture;
  logic                    pop;

  always_comb begin
    tag_shift    = '0;
    tag_shift[0] = o_fifo_read;
    for (int i = 1; i < READ_LATENCY; i++) tag_shift[i] = tag_sr[i-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(tag_sr[i]);
  end

  // Credit counts buffered plus in-flight words; i_ready never enters the issue term.
  assign credit      = {1'b0, occ} + {1'b0, inflight};
  assign o_fifo_read = i_reset_n & ~i_flush & ~i_fifo_empty & (credit < BUF_LIMIT);

  // Stage boundary: read strobe -> tag pipeline aligned with the FIFO read latency
  always_ff @(posedge i_clock) begin
    if (!i_reset_n || i_flush) tag_sr <= '0;
    else                       tag_sr <= tag_shift;
  end

  // A flush voids both the returning word and any handshake in the same cycle.
  assign capture = tag_sr[READ_LATENCY-1] & ~i_flush;
  assign pop     = o_valid & i_ready & ~i_flush;

  // Stage boundary: returning data -> skid buffer, visible on the next cycle
  fifo_stream_reader_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF)
  ) u_buf (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .clear     (i_flush),
    .wr        (capture),
    .wdata     (i_fifo_rdata),
    .rd        (pop),
    .rdata     (o_data),
    .count     (occ)
  );

  assign o_valid = (occ != '0);
  assign o_count = occ;

  always_ff @(posedge i_clock) begin
    if (i_reset_n) begin
      assert (credit <= BUF_LIMIT);
      assert (!(o_fifo_read && i_fifo_empty));
    end
  end

endmodule
